axi_dma_req_arbiter: RTL and testbench

Shares one DMA backend between NUM_REQ frontends, such as cores or cluster ports.
- Round-robin arbitration of transfer descriptors onto the single backend request channel.
- Assigns a monotonically increasing transfer ID to each accepted transfer.
- Tracks which requester owns each outstanding transfer and routes in-order completions back to it.
- Drives next_id/completed_id/busy for the performance-counter block.

---
 rtl/axi_dma_pkg.sv | 11 +
 rtl/fifo_v3.sv | 49 ++++
 rtl/axi_dma_req_arbiter.sv | 155 +++++++++++++++
 tb/tb_axi_dma_req_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_pkg.sv
// Shared constants and helpers for the DMA request arbiter.
// Transfer ID 0 is reserved to mean "no transfer".
package axi_dma_pkg;

    localparam int unsigned ID_NONE = 0;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO (common_cells fifo_v3 subset) holding owner indices.
// Push to a full FIFO and pop from an empty one are ignored.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      rd_q;
    logic [PTR_W-1:0]      wr_q;
    logic [PTR_W:0]        cnt_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Storage needs no reset; occupancy tracking guards every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/axi_dma_req_arbiter.sv
// Round-robin arbiter sharing one DMA backend among NUM_REQ frontends.
// Optional AXI_DMA_ARB_PRIO_EN adds 2-bit per-requester priority (prio_i).
module axi_dma_req_arbiter
    import axi_dma_pkg::*;
#(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned TRANSFER_ID_WIDTH = 32,
    parameter int unsigned MAX_OUTSTANDING   = 8,
    parameter type         burst_req_t       = logic
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  burst_req_t [NUM_REQ-1:0]     req_i,
`ifdef AXI_DMA_ARB_PRIO_EN
    input  logic [NUM_REQ-1:0][1:0]      prio_i,
`endif
    output logic [TRANSFER_ID_WIDTH-1:0] req_id_o,
    output burst_req_t                   be_req_o,
    output logic                         be_valid_o,
    input  logic                         be_ready_i,
    input  logic                         be_done_i,
    output logic [NUM_REQ-1:0]           done_o,
    output logic [TRANSFER_ID_WIDTH-1:0] next_id_o,
    output logic [TRANSFER_ID_WIDTH-1:0] completed_id_o,
    output logic                         busy_o
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    typedef logic [IDX_W-1:0]             idx_t;
    typedef logic [TRANSFER_ID_WIDTH-1:0] id_t;

    function automatic idx_t wrap_idx(input int unsigned v);
        return idx_t'(v % NUM_REQ);
    endfunction

    function automatic id_t id_inc(input id_t v);
        return (v == '1) ? id_t'(ID_NONE + 1) : v + 1'b1;
    endfunction

    idx_t               rr_q;
    idx_t               lock_idx_q;
    logic               lock_q;
    id_t                next_id_q;
    id_t                completed_id_q;
    logic [NUM_REQ-1:0] done_q;
    logic               busy_q;

    logic [NUM_REQ-1:0] elig;
    idx_t               rr_pick;
    idx_t               grant;
    idx_t               head;
    logic               found;
    logic               any_valid;
    logic               full;
    logic               empty;
    logic               hs;
    logic               pop;

`ifdef AXI_DMA_ARB_PRIO_EN
    logic [1:0] top_prio;

    // Only requesters at the highest requesting level take part in RR.
    always_comb begin
        top_prio = '0;
        elig     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid_i[i] && (prio_i[i] > top_prio)) top_prio = prio_i[i];
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid_i[i] && (prio_i[i] == top_prio);
        end
    end
`else
    assign elig = req_valid_i;
`endif

    always_comb begin
        rr_pick = rr_q;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && elig[wrap_idx(32'(rr_q) + i)]) begin
                rr_pick = wrap_idx(32'(rr_q) + i);
                found   = 1'b1;
            end
        end
    end

    // A stalled offer keeps its owner until the backend accepts it.
    assign grant      = lock_q ? lock_idx_q : rr_pick;
    assign any_valid  = |req_valid_i;
    assign be_valid_o = any_valid & ~full;
    assign be_req_o   = req_i[grant];
    assign hs         = be_valid_o & be_ready_i;
    assign pop        = be_done_i & ~empty;

    always_comb begin
        req_ready_o        = '0;
        req_ready_o[grant] = be_ready_i & ~full & req_valid_i[grant];
    end

    assign req_id_o       = next_id_q;
    assign next_id_o      = next_id_q;
    assign completed_id_o = completed_id_q;
    assign done_o         = done_q;
    assign busy_o         = busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q           <= '0;
            lock_q         <= 1'b0;
            lock_idx_q     <= '0;
            next_id_q      <= id_t'(ID_NONE + 1);
            completed_id_q <= id_t'(ID_NONE);
            done_q         <= '0;
            busy_q         <= 1'b0;
        end else begin
            lock_q     <= be_valid_o & ~be_ready_i;
            lock_idx_q <= grant;
            busy_q     <= ~empty | be_valid_o;
            done_q     <= '0;
            if (hs) begin
                rr_q      <= wrap_idx(32'(grant) + 1);
                next_id_q <= id_inc(next_id_q);
            end
            if (pop) begin
                done_q[head]   <= 1'b1;
                completed_id_q <= id_inc(completed_id_q);
            end
        end
    end

    fifo_v3 #(
        .DATA_WIDTH (IDX_W),
        .DEPTH      (MAX_OUTSTANDING)
    ) i_owner_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .data_i  (grant),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

`ifndef SYNTHESIS
    spurious_done: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(be_done_i && empty)
    ) else $warning("be_done_i with no outstanding transfer ignored");
`endif

endmodule

// File: tb/tb_axi_dma_req_arbiter.sv
// Directed bench for axi_dma_req_arbiter with 4-bit IDs to exercise wrap.
// Expected grants, IDs and owners are worked out by hand per step.
module tb_axi_dma_req_arbiter;

    typedef logic [7:0] desc_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    desc_t [3:0]     req_data;
    logic [3:0]      req_id;
    desc_t           be_req;
    logic            be_valid;
    logic            be_ready;
    logic            be_done;
    logic [3:0]      done;
    logic [3:0]      next_id;
    logic [3:0]      completed_id;
    logic            busy;
`ifdef AXI_DMA_ARB_PRIO_EN
    logic [3:0][1:0] prio;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_id;
    logic [3:0] exp_cid;

    always #5 clk = ~clk;

    axi_dma_req_arbiter #(
        .NUM_REQ           (4),
        .TRANSFER_ID_WIDTH (4),
        .MAX_OUTSTANDING   (8),
        .burst_req_t       (desc_t)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_i          (req_data),
`ifdef AXI_DMA_ARB_PRIO_EN
        .prio_i         (prio),
`endif
        .req_id_o       (req_id),
        .be_req_o       (be_req),
        .be_valid_o     (be_valid),
        .be_ready_i     (be_ready),
        .be_done_i      (be_done),
        .done_o         (done),
        .next_id_o      (next_id),
        .completed_id_o (completed_id),
        .busy_o         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] nx(input logic [3:0] v);
        return (v == 4'hF) ? 4'h1 : v + 4'h1;
    endfunction

    task automatic pop_check(input logic [3:0] owner);
        be_done = 1'b1;
        tick();
        be_done = 1'b0;
        #1;
        exp_cid = nx(exp_cid);
        check("done_owner", done, owner);
        check("completed_id", completed_id, exp_cid);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] t_rdy [4];
        desc_t      t_dat [4];
        t_rdy = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        t_dat = '{8'hA0, 8'hA2, 8'hA0, 8'hA2};

        rst_n     = 1'b0;
        req_valid = '0;
        be_ready  = 1'b0;
        be_done   = 1'b0;
        for (int i = 0; i < 4; i++) req_data[i] = desc_t'(8'hA0 + i);
`ifdef AXI_DMA_ARB_PRIO_EN
        prio = '0;
`endif
        exp_id  = 4'h1;
        exp_cid = 4'h0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_next_id", next_id, 4'h1);
        check("rst_completed", completed_id, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_be_valid", be_valid, 1'b0);
        check("rst_ready", req_ready, 4'b0000);
        check("rst_done", done, 4'b0000);
        tick();
        check("idle_busy", busy, 1'b0);

        // Round robin between requesters 0 and 2.
        req_valid = 4'b0101;
        be_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready", req_ready, t_rdy[i]);
            check("rr_data", be_req, t_dat[i]);
            check("rr_id", req_id, exp_id);
            tick();
            exp_id = nx(exp_id);
        end
        req_valid = '0;
        #1;
        check("rr_busy", busy, 1'b1);
        pop_check(4'b0001);
        pop_check(4'b0100);
        pop_check(4'b0001);
        pop_check(4'b0100);
        tick();
        check("drain_done_clr", done, 4'b0000);
        check("drain_busy", busy, 1'b0);

        // Stall on requester 1 while requester 0 joins; lock must hold.
        req_valid = 4'b0010;
        be_ready  = 1'b0;
        #1;
        check("stall_valid", be_valid, 1'b1);
        check("stall_ready", req_ready, 4'b0000);
        check("stall_data0", be_req, 8'hA1);
        tick();
        req_valid = 4'b0011;
        #1;
        check("stall_data1", be_req, 8'hA1);
        tick();
        check("stall_data2", be_req, 8'hA1);
        be_ready = 1'b1;
        #1;
        check("stall_hs_ready", req_ready, 4'b0010);
        check("stall_hs_id", req_id, exp_id);
        tick();
        exp_id    = nx(exp_id);
        req_valid = 4'b0001;
        #1;
        check("after_ready", req_ready, 4'b0001);
        check("after_data", be_req, 8'hA0);
        check("after_id", req_id, exp_id);
        tick();
        exp_id    = nx(exp_id);
        req_valid = '0;
        pop_check(4'b0010);
        pop_check(4'b0001);

        // Fill the ownership FIFO from requester 3.
        req_valid = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("fill_id", req_id, exp_id);
            check("fill_ready", req_ready, 4'b1000);
            tick();
            exp_id = nx(exp_id);
        end
        #1;
        check("full_valid", be_valid, 1'b0);
        check("full_ready", req_ready, 4'b0000);
        be_done = 1'b1;
        #1;
        check("full_pop_valid", be_valid, 1'b0);
        tick();
        be_done = 1'b0;
        #1;
        exp_cid = nx(exp_cid);
        check("full_done", done, 4'b1000);
        check("full_completed", completed_id, exp_cid);
        check("refill_valid", be_valid, 1'b1);
        check("allones_id", req_id, 4'hF);
        tick();
        exp_id = nx(exp_id);
        check("refull_valid", be_valid, 1'b0);
        pop_check(4'b1000);
        check("wrap_valid", be_valid, 1'b1);
        check("wrap_id", req_id, 4'h1);
        tick();
        exp_id    = nx(exp_id);
        req_valid = '0;
        #1;
        check("wrap_next_id", next_id, 4'h2);
        for (int i = 0; i < 8; i++) pop_check(4'b1000);
        check("cid_wrapped", completed_id, 4'h1);
        tick();
        check("fill_done_clr", done, 4'b0000);

        // Spurious completion with nothing outstanding.
        be_done = 1'b1;
        tick();
        be_done = 1'b0;
        #1;
        check("spur_done", done, 4'b0000);
        check("spur_completed", completed_id, exp_cid);
        tick();
        check("spur_busy", busy, 1'b0);

        // Reset in the middle of traffic.
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = '0;
        #1;
        check("pre_rst_next_id", next_id, nx(exp_id));
        rst_n = 1'b0;
        #1;
        check("mid_rst_next_id", next_id, 4'h1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_completed", completed_id, 4'h0);
        check("mid_rst_done", done, 4'b0000);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", be_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
